// File: rtl/video_pkg.sv
// Shared types and constants for the raster timing generator and the TMDS encoders.
//   seg_state_t   : segment of one raster axis (active, front porch, sync, back porch)
//   axis_timing_t : segment lengths for one axis, in pixels or lines
//   TMDS_CTRL_*   : 10-bit TMDS control tokens, indexed by ctrl = {c1,c0}
package video_pkg;

  localparam logic [1:0] SEG_ACT  = 2'd0;
  localparam logic [1:0] SEG_FP   = 2'd1;
  localparam logic [1:0] SEG_SYNC = 2'd2;
  localparam logic [1:0] SEG_BP   = 2'd3;

  typedef enum logic [1:0] {
    ACT  = SEG_ACT,
    FP   = SEG_FP,
    SYNC = SEG_SYNC,
    BP   = SEG_BP
  } seg_state_t;

  typedef struct packed {
    logic [11:0] active;
    logic [11:0] fp;
    logic [11:0] sync;
    logic [11:0] bp;
  } axis_timing_t;

  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  // Length-1 of the given segment; used to reload the segment down-counter.
  function automatic logic [11:0] seg_len_m1(input seg_state_t s, input axis_timing_t t);
    logic [11:0] len;
    case (s)
      ACT:     len = t.active;
      FP:      len = t.fp;
      SYNC:    len = t.sync;
      default: len = t.bp;
    endcase
    return len - 12'd1;
  endfunction

  function automatic seg_state_t seg_next(input seg_state_t s);
    seg_state_t n;
    case (s)
      ACT:     n = FP;
      FP:      n = SYNC;
      SYNC:    n = BP;
      default: n = ACT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: segment FSM with a down-counter plus an absolute position counter.
// Ports:
//   i_clk     pixel clock
//   i_rst_n   synchronous active-low reset
//   i_step    advance one position this cycle
//   i_timing  segment lengths for this axis
//   o_pos     absolute position within the axis (0 .. total-1)
//   o_state   current segment
//   o_wrap    combinational: this step leaves the last position of the axis
//
// state | meaning
// ACT   | visible pixels / lines
// FP    | front porch
// SYNC  | sync pulse
// BP    | back porch; its last position ends the axis
module vtg_axis_counter
  import video_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_step,
  input  axis_timing_t i_timing,
  output logic [11:0]  o_pos,
  output seg_state_t   o_state,
  output logic         o_wrap
);

  seg_state_t  r_state;
  logic [11:0] r_seg_cnt;
  logic [11:0] r_pos;
  logic        w_seg_done;
  seg_state_t  w_next;

  assign w_seg_done = (r_seg_cnt == 12'd0);
  assign w_next     = seg_next(r_state);
  assign o_wrap     = i_step && w_seg_done && (r_state == BP);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ACT;
      r_seg_cnt <= seg_len_m1(ACT, i_timing);
      r_pos     <= 12'd0;
    end else if (i_step) begin
      r_pos <= o_wrap ? 12'd0 : r_pos + 12'd1;
      if (w_seg_done) begin
        r_state   <= w_next;
        r_seg_cnt <= seg_len_m1(w_next, i_timing);
      end else begin
        r_seg_cnt <= r_seg_cnt - 12'd1;
      end
    end
  end

  assign o_pos   = r_pos;
  assign o_state = r_state;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator feeding the TMDS encoders.
// Optional feature: define VTG_PATTERN_EN to build the 8-bar colour-bar source;
// otherwise o_pat_* are tied to 0.
// Ports:
//   i_clk          pixel clock
//   i_rst_n        synchronous active-low reset (wins over i_en)
//   i_en           pixel enable; 0 freezes counters and outputs
//   o_de           data enable, high in the active area
//   o_ctrl         {vsync,hsync} at configured polarity
//   o_x, o_y       pixel column/row while o_de, else 0
//   o_frame_start  1-cycle pulse with pixel (0,0)
//   o_pat_r/g/b    colour-bar data aligned with o_de
// All outputs are registered one clock after the counter value they decode.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  output logic        o_de,
  output logic [1:0]  o_ctrl,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_frame_start,
  output logic [7:0]  o_pat_r,
  output logic [7:0]  o_pat_g,
  output logic [7:0]  o_pat_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_params
    $error("video_timing_gen: segment lengths must be >= 1 and totals <= 4096");
  end

  localparam axis_timing_t H_TIMING = '{
    active: 12'(H_ACTIVE), fp: 12'(H_FP), sync: 12'(H_SYNC), bp: 12'(H_BP)};
  localparam axis_timing_t V_TIMING = '{
    active: 12'(V_ACTIVE), fp: 12'(V_FP), sync: 12'(V_SYNC), bp: 12'(V_BP)};

  logic [11:0] w_h_pos;
  logic [11:0] w_v_pos;
  seg_state_t  w_h_state;
  seg_state_t  w_v_state;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_v_step;
  logic        w_de;

  // The vertical axis steps on the edge that wraps the line, so a new vsync
  // state becomes visible together with h_cnt=0.
  assign w_v_step = i_en && w_h_wrap;

  vtg_axis_counter u_h_axis (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_step   (i_en),
    .i_timing (H_TIMING),
    .o_pos    (w_h_pos),
    .o_state  (w_h_state),
    .o_wrap   (w_h_wrap)
  );

  vtg_axis_counter u_v_axis (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_step   (w_v_step),
    .i_timing (V_TIMING),
    .o_pos    (w_v_pos),
    .o_state  (w_v_state),
    .o_wrap   (w_v_wrap)
  );

  assign w_de = (w_h_state == ACT) && (w_v_state == ACT);

  logic        r_de;
  logic [1:0]  r_ctrl;
  logic [11:0] r_x;
  logic [11:0] r_y;
  logic        r_frame_start;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_de          <= 1'b0;
      r_ctrl        <= {~VS_POL, ~HS_POL};
      r_x           <= 12'd0;
      r_y           <= 12'd0;
      r_frame_start <= 1'b0;
    end else if (i_en) begin
      r_de          <= w_de;
      r_ctrl[1]     <= (w_v_state == SYNC) ? VS_POL : ~VS_POL;
      r_ctrl[0]     <= (w_h_state == SYNC) ? HS_POL : ~HS_POL;
      r_x           <= w_de ? w_h_pos : 12'd0;
      r_y           <= w_de ? w_v_pos : 12'd0;
      r_frame_start <= (w_h_pos == 12'd0) && (w_v_pos == 12'd0);
    end
  end

  assign o_de          = r_de;
  assign o_ctrl        = r_ctrl;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_frame_start = r_frame_start;

`ifdef VTG_PATTERN_EN
  // Bar width never drops below one pixel so narrow test rasters still divide.
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [11:0] w_bar_raw;
  logic [2:0]  w_bar;
  logic [7:0]  r_pat_r;
  logic [7:0]  r_pat_g;
  logic [7:0]  r_pat_b;

  assign w_bar_raw = w_h_pos / 12'(BAR_W);
  assign w_bar     = (w_bar_raw > 12'd7) ? 3'd7 : w_bar_raw[2:0];

  // Bar order white,yellow,cyan,green,magenta,red,blue,black falls out of the
  // index bits: red off for bars 2,3,6,7; green off for 4..7; blue off for odd.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pat_r <= 8'h00;
      r_pat_g <= 8'h00;
      r_pat_b <= 8'h00;
    end else if (i_en) begin
      r_pat_r <= (w_de && !w_bar[1]) ? 8'hFF : 8'h00;
      r_pat_g <= (w_de && !w_bar[2]) ? 8'hFF : 8'h00;
      r_pat_b <= (w_de && !w_bar[0]) ? 8'hFF : 8'h00;
    end
  end

  assign o_pat_r = r_pat_r;
  assign o_pat_g = r_pat_g;
  assign o_pat_b = r_pat_b;
`else
  assign o_pat_r = 8'h00;
  assign o_pat_g = 8'h00;
  assign o_pat_b = 8'h00;
`endif

endmodule
